thread_issue_queue: RTL

Parametrised per-thread instruction buffer between instruction decode and operand fetch, replacing the single-slot, fixed-thread-count handoff in the current core pipeline. It holds NUM_THREADS independent FIFOs of decoded instructions, drives per-thread fetch enables from FIFO occupancy, and issues one instruction per cycle by round-robin among eligible threads. It also handles rollback flushes per thread and produces a drained-aware processor halt.

---
 rtl/thread_issue_queue.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/thread_issue_queue.sv
// thread_issue_queue: per-thread decoded-instruction FIFOs between decode and
// operand fetch. Issues one instruction per cycle by round-robin among eligible
// threads, supports per-thread rollback flush, occupancy-driven fetch enables
// and a drained-aware halt indication.
module thread_issue_queue #(
  parameter int NUM_THREADS  = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int FETCH_MARGIN = 3,
  parameter int INSTR_WIDTH  = 128,
  parameter int TIDX_W       = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_instruction_valid,
  input  logic [INSTR_WIDTH-1:0] id_instruction,
  input  logic [TIDX_W-1:0]      id_thread_idx,
  input  logic [NUM_THREADS-1:0] thread_enable,
  input  logic [NUM_THREADS-1:0] thread_stall,
  input  logic                   rollback_en,
  input  logic [TIDX_W-1:0]      rollback_thread_idx,
  output logic [NUM_THREADS-1:0] fetch_en,
  output logic                   iq_instruction_valid,
  output logic [INSTR_WIDTH-1:0] iq_instruction,
  output logic [TIDX_W-1:0]      iq_thread_idx,
  output logic                   processor_halt,
  output logic                   overflow_err
);

  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int ADDR_W     = TIDX_W + PTR_W;
  localparam int FETCH_LIMIT = FIFO_DEPTH - FETCH_MARGIN - 1;

  // Storage for all threads in one array, addressed {thread, pointer}
  logic [INSTR_WIDTH-1:0] mem_q [NUM_THREADS*FIFO_DEPTH];

  logic [PTR_W-1:0] rd_q    [NUM_THREADS];
  logic [PTR_W-1:0] rd_d    [NUM_THREADS];
  logic [PTR_W-1:0] wr_q    [NUM_THREADS];
  logic [PTR_W-1:0] wr_d    [NUM_THREADS];
  logic [CNT_W-1:0] count_q [NUM_THREADS];
  logic [CNT_W-1:0] count_d [NUM_THREADS];

  logic [TIDX_W-1:0]      last_q;
  logic [NUM_THREADS-1:0] eligible;
  logic [NUM_THREADS-1:0] flush;
  logic [NUM_THREADS-1:0] fetch_en_d;
  logic [NUM_THREADS-1:0] fetch_en_q;
  logic                   issue;
  logic [TIDX_W-1:0]      sel;
  logic [TIDX_W-1:0]      cand;
  logic                   push_req;
  logic                   push_accept;
  logic                   push_drop;
  logic [ADDR_W-1:0]      wr_addr;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   all_empty_d;
  logic                   iq_valid_q;
  logic [INSTR_WIDTH-1:0] iq_instr_q;
  logic [TIDX_W-1:0]      iq_tidx_q;
  logic                   halt_q;
  logic                   overflow_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
      // A thread being flushed this cycle must not issue: its head is wrong-path
      assign flush[gi]    = rollback_en && (rollback_thread_idx == TIDX_W'(gi));
      assign eligible[gi] = (count_q[gi] != '0) && thread_enable[gi] &&
                            !thread_stall[gi] && !flush[gi];
      assign fetch_en_d[gi] = thread_enable[gi] &&
                              (count_d[gi] <= CNT_W'(FETCH_LIMIT));
    end
  endgenerate

  // Round-robin pick: scan starting one past the last issued thread
  always_comb begin
    issue = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int off = 1; off <= NUM_THREADS; off++) begin
      cand = last_q + TIDX_W'(off);
      if (!issue && eligible[cand]) begin
        issue = 1'b1;
        sel   = cand;
      end
    end
  end

  // Push acceptance and per-thread pointer/count next state
  always_comb begin
    push_req    = id_instruction_valid && !flush[id_thread_idx];
    push_accept = push_req &&
                  ((count_q[id_thread_idx] != CNT_W'(FIFO_DEPTH)) ||
                   (issue && (sel == id_thread_idx)));
    push_drop   = push_req && !push_accept;
    wr_addr     = {id_thread_idx, wr_q[id_thread_idx]};
    rd_addr     = {sel, rd_q[sel]};
    all_empty_d = 1'b1;
    for (int t = 0; t < NUM_THREADS; t++) begin
      logic acc;
      logic pop;
      acc = push_accept && (id_thread_idx == TIDX_W'(t));
      pop = issue && (sel == TIDX_W'(t));
      if (flush[t]) begin
        // Rollback discards contents and any same-cycle push
        rd_d[t]    = wr_q[t];
        wr_d[t]    = wr_q[t];
        count_d[t] = '0;
      end else begin
        rd_d[t]    = rd_q[t] + PTR_W'(pop);
        wr_d[t]    = wr_q[t] + PTR_W'(acc);
        count_d[t] = count_q[t] + CNT_W'(acc) - CNT_W'(pop);
      end
      if (count_d[t] != '0) begin
        all_empty_d = 1'b0;
      end
    end
  end

  // Instruction storage write port; pushes during reset are ignored
  always_ff @(posedge clk) begin
    if (reset && push_accept) begin
      mem_q[wr_addr] <= id_instruction;
    end
  end

  // Pointer, count, arbitration and registered output state
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        rd_q[t]    <= '0;
        wr_q[t]    <= '0;
        count_q[t] <= '0;
      end
      last_q     <= TIDX_W'(NUM_THREADS - 1);
      fetch_en_q <= '0;
      iq_valid_q <= 1'b0;
      iq_instr_q <= '0;
      iq_tidx_q  <= '0;
      halt_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        rd_q[t]    <= rd_d[t];
        wr_q[t]    <= wr_d[t];
        count_q[t] <= count_d[t];
      end
      iq_valid_q <= issue;
      if (issue) begin
        last_q     <= sel;
        iq_instr_q <= mem_q[rd_addr];
        iq_tidx_q  <= sel;
      end
      fetch_en_q <= fetch_en_d;
      halt_q     <= (thread_enable == '0) && all_empty_d && !issue;
      if (push_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign fetch_en             = fetch_en_q;
  assign iq_instruction_valid = iq_valid_q;
  assign iq_instruction       = iq_instr_q;
  assign iq_thread_idx        = iq_tidx_q;
  assign processor_halt       = halt_q;
  assign overflow_err         = overflow_q;

endmodule
